// File: rtl/branch_resolve_if.sv
// Issue-side request, resolution status and fetch redirect signals of the
// branch resolution controller, bundled for a single port connection.
interface branch_resolve_if #(
  parameter int CNT_W = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [31:0]      req_pc;
  logic [31:0]      req_target;
  logic             req_pred_taken;
  logic             resolve_valid;
  logic             resolve_taken;
  logic             resolve_mispredict;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             redirect_ack;
  logic             flush;
  logic [CNT_W-1:0] mispredict_count;
  logic             illegal_op;

  // controller side
  modport slave (
    input  req_valid, req_op, req_a, req_b, req_pc, req_target, req_pred_taken,
    input  redirect_ack,
    output req_ready, resolve_valid, resolve_taken, resolve_mispredict,
    output redirect_valid, redirect_pc, flush, mispredict_count, illegal_op
  );

  // issue / fetch side
  modport master (
    output req_valid, req_op, req_a, req_b, req_pc, req_target, req_pred_taken,
    output redirect_ack,
    input  req_ready, resolve_valid, resolve_taken, resolve_mispredict,
    input  redirect_valid, redirect_pc, flush, mispredict_count, illegal_op
  );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller: queues issued conditional branches in order,
// evaluates the head through a shared comparator, and on a mispredict holds
// a redirect to fetch until it is acknowledged, then flushes younger work.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | queue empty, waiting for a branch from issue
// EVAL     | head of queue on the comparator; pop if prediction was right
// REDIRECT | mispredict: redirect_valid high until fetch acks, pushes blocked

module cmp_module (
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        taken
);
  // RISC-V branch compare on funct3; unsupported codes report not-taken
  always_comb begin
    taken = 1'b0;
    case (op)
      3'b000:  taken = (a == b);
      3'b001:  taken = (a != b);
      3'b100:  taken = ($signed(a) <  $signed(b));
      3'b101:  taken = ($signed(a) >= $signed(b));
      3'b110:  taken = (a <  b);
      3'b111:  taken = (a >= b);
      default: taken = 1'b0;
    endcase
  end
endmodule

module branch_resolve_ctrl #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input logic             clk,
  input logic             rst,
  branch_resolve_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [31:0] target;
    logic        pred;
  } entry_t;

  typedef enum logic [1:0] {IDLE, EVAL, REDIRECT} state_t;

  state_t           state, state_nxt;
  entry_t           q_mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;

  entry_t           head;
  entry_t           req_entry;
  logic             head_illegal;
  logic [2:0]       cmp_op;
  logic             cmp_taken;
  logic             taken;
  logic             mispred;
  logic             full;
  logic             ready;
  logic             push;
  logic             pop;
  logic             clear;
  logic             mis_fire;

  logic             resolve_valid_q;
  logic             resolve_taken_q;
  logic             resolve_mis_q;
  logic             flush_q;
  logic [31:0]      redirect_pc_q;
  logic             outcome_q;
  logic [CNT_W-1:0] mis_cnt_q;
  logic             illegal_q;

  assign head         = q_mem[rd_ptr];
  assign head_illegal = (head.op[2:1] == 2'b01);
  // illegal funct3 is steered to beq so the comparator never sees it
  assign cmp_op       = head_illegal ? 3'b000 : head.op;
  assign taken        = cmp_taken & ~head_illegal;
  assign mispred      = (taken != head.pred);

  cmp_module u_cmp (
    .op    (cmp_op),
    .a     (head.a),
    .b     (head.b),
    .taken (cmp_taken)
  );

  assign full  = (count == CW'(DEPTH));
  assign ready = !full && (state != REDIRECT);
  assign push  = bus.req_valid && ready;

  assign req_entry = '{op: bus.req_op, a: bus.req_a, b: bus.req_b,
                       pc: bus.req_pc, target: bus.req_target,
                       pred: bus.req_pred_taken};

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state and queue control decode
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    clear     = 1'b0;
    mis_fire  = 1'b0;
    case (state)
      IDLE: begin
        if (push) state_nxt = EVAL;
      end
      EVAL: begin
        if (mispred) begin
          mis_fire  = 1'b1;
          state_nxt = REDIRECT;
        end else begin
          pop = 1'b1;
          // entries left after this pop, counting a same-cycle push
          if ((count > CW'(1)) || push) state_nxt = EVAL;
          else                          state_nxt = IDLE;
        end
      end
      REDIRECT: begin
        if (bus.redirect_ack) begin
          clear     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // queue pointers and occupancy; a redirect ack drops head and all younger
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // queue storage; occupancy alone defines validity so no reset is needed
  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr] <= req_entry;
  end

  // resolution pulses, redirect target, mispredict counter and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resolve_valid_q <= 1'b0;
      resolve_taken_q <= 1'b0;
      resolve_mis_q   <= 1'b0;
      flush_q         <= 1'b0;
      redirect_pc_q   <= '0;
      outcome_q       <= 1'b0;
      mis_cnt_q       <= '0;
      illegal_q       <= 1'b0;
    end else begin
      resolve_valid_q <= 1'b0;
      resolve_mis_q   <= 1'b0;
      flush_q         <= 1'b0;
      if (state == EVAL && head_illegal) illegal_q <= 1'b1;
      if (pop) begin
        resolve_valid_q <= 1'b1;
        resolve_taken_q <= taken;
      end
      if (mis_fire) begin
        redirect_pc_q <= taken ? head.target : head.pc + 32'd4;
        outcome_q     <= taken;
      end
      if (clear) begin
        resolve_valid_q <= 1'b1;
        resolve_mis_q   <= 1'b1;
        resolve_taken_q <= outcome_q;
        flush_q         <= 1'b1;
        if (!(&mis_cnt_q)) mis_cnt_q <= mis_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.req_ready          = ready;
  assign bus.resolve_valid      = resolve_valid_q;
  assign bus.resolve_taken      = resolve_taken_q;
  assign bus.resolve_mispredict = resolve_mis_q;
  assign bus.redirect_valid     = (state == REDIRECT);
  assign bus.redirect_pc        = redirect_pc_q;
  assign bus.flush              = flush_q;
  assign bus.mispredict_count   = mis_cnt_q;
  assign bus.illegal_op         = illegal_q;
endmodule
